output_stream_buffer: RTL and testbench

- Stage directly downstream of the array control FSM and PE array.
- Captures result words qualified by validOutputs into a first-word-fall-through FIFO and presents them on a master AXI-Stream port with full TREADY backpressure.
- Generates TLAST every WORDS_PER_PACKET beats.
- Flags any result lost because the buffer was full; the producer side has no backpressure.

---
 rtl/stream_pkg.sv | 11 +
 rtl/output_stream_buffer_if.sv | 27 ++
 rtl/sync_fifo_fwft.sv | 70 +++++++
 rtl/output_stream_buffer.sv | 78 +++++++
 tb/tb_output_stream_buffer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/stream_pkg.sv
// Shared stream constants and width helpers used by the array-side stream blocks.
package stream_pkg;

    localparam int AXIS_DATA_WIDTH = 32;

    // A $clog2 that never returns 0, so a 1-entry range still gets a real bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage : stream_pkg

// File: rtl/output_stream_buffer_if.sv
// Master AXI-Stream bundle carried from the result buffer to the downstream consumer.
interface output_stream_buffer_if
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH
);

    logic                  M_AXIS_TVALID;
    logic                  M_AXIS_TREADY;
    logic [DATA_WIDTH-1:0] M_AXIS_TDATA;
    logic                  M_AXIS_TLAST;

    modport master (
        output M_AXIS_TVALID,
        output M_AXIS_TDATA,
        output M_AXIS_TLAST,
        input  M_AXIS_TREADY
    );

    modport slave (
        input  M_AXIS_TVALID,
        input  M_AXIS_TDATA,
        input  M_AXIS_TLAST,
        output M_AXIS_TREADY
    );

endinterface : output_stream_buffer_if

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with wrap-flag pointers; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module sync_fifo_fwft
    import stream_pkg::*;
#(
    parameter  int DATA_WIDTH  = AXIS_DATA_WIDTH,
    parameter  int DEPTH       = 8,
    localparam int PTR_WIDTH   = clog2_min1(DEPTH),
    localparam int LEVEL_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_req_i,
    input  logic                   pop_i,
    input  logic [DATA_WIDTH-1:0]  wr_data_i,
    output logic [DATA_WIDTH-1:0]  rd_data_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [LEVEL_WIDTH-1:0] level_o
);

    localparam logic [PTR_WIDTH:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0]    rd_ptr_q, rd_ptr_d;
    logic                  push, pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]) &&
                     (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]);
    assign level_o = LEVEL_WIDTH'(wr_ptr_q - rd_ptr_q);

    assign pop  = pop_i & ~empty_o & ~flush_i;
    assign push = push_req_i & (~full_o | pop) & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; emptiness comes from the pointers
    // and the read port is masked, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= wr_data_i;
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[PTR_WIDTH-1:0]];

endmodule : sync_fifo_fwft

// File: rtl/output_stream_buffer.sv
// Buffers array results into a FWFT FIFO and streams them out as AXI-Stream
// packets of WORDS_PER_PACKET beats; results arriving while full are dropped and flagged.
module output_stream_buffer
    import stream_pkg::*;
#(
    parameter  int DATA_WIDTH       = AXIS_DATA_WIDTH,
    parameter  int DEPTH            = 8,
    parameter  int WORDS_PER_PACKET = 2,
    localparam int PTR_WIDTH        = clog2_min1(DEPTH),
    localparam int LEVEL_WIDTH      = $clog2(DEPTH + 1),
    localparam int BEAT_WIDTH       = $clog2(WORDS_PER_PACKET + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    validOutputs,
    input  logic [DATA_WIDTH-1:0]   result_data,
    output logic [LEVEL_WIDTH-1:0]  level,
    output logic                    overflow,
    output_stream_buffer_if.master  m_axis
);

    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(WORDS_PER_PACKET - 1);
    localparam logic [BEAT_WIDTH-1:0] BEAT_ONE  = 1;

    logic                  empty, full, pop, drop, last_beat;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [BEAT_WIDTH-1:0] beat_q, beat_d;
    logic                  overflow_q, overflow_d;

    sync_fifo_fwft #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (clear),
        .push_req_i (validOutputs),
        .pop_i      (pop),
        .wr_data_i  (result_data),
        .rd_data_o  (rd_data),
        .empty_o    (empty),
        .full_o     (full),
        .level_o    (level)
    );

    // clear outranks everything: no pop, no beat advance, no drop flagged.
    assign pop       = ~empty & m_axis.M_AXIS_TREADY & ~clear;
    assign drop      = validOutputs & full & ~pop & ~clear;
    assign last_beat = (beat_q == LAST_BEAT);

    always_comb begin
        beat_d     = beat_q;
        overflow_d = overflow_q | drop;
        if (clear) begin
            beat_d     = '0;
            overflow_d = 1'b0;
        end else if (pop) begin
            beat_d = last_beat ? '0 : beat_q + BEAT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            beat_q     <= beat_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow             = overflow_q;
    assign m_axis.M_AXIS_TVALID = ~empty;
    assign m_axis.M_AXIS_TDATA  = rd_data;
    assign m_axis.M_AXIS_TLAST  = ~empty & last_beat;

endmodule : output_stream_buffer

// File: tb/tb_output_stream_buffer.sv
// Directed bench for output_stream_buffer: DATA_WIDTH=32, DEPTH=8, WORDS_PER_PACKET=2.
module tb_output_stream_buffer;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic          validOutputs = 1'b0;
    logic [DW-1:0] result_data = '0;
    logic [3:0]    level;
    logic          overflow;

    int n_cmp = 0;
    int n_err = 0;

    output_stream_buffer_if #(.DATA_WIDTH(DW)) m_axis ();

    output_stream_buffer #(
        .DATA_WIDTH       (DW),
        .DEPTH            (8),
        .WORDS_PER_PACKET (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .validOutputs (validOutputs),
        .result_data  (result_data),
        .level        (level),
        .overflow     (overflow),
        .m_axis       (m_axis)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [DW-1:0] first, input int count);
        for (int i = 0; i < count; i++) begin
            validOutputs = 1'b1;
            result_data  = first + DW'(i);
            tick();
        end
        validOutputs = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (m_axis.M_AXIS_TVALID !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got=%b exp=0", m_axis.M_AXIS_TVALID); end
        n_cmp++; if (m_axis.M_AXIS_TDATA !== 32'h0) begin n_err++; $display("FAIL reset_tdata got=%h exp=0", m_axis.M_AXIS_TDATA); end
        n_cmp++; if (m_axis.M_AXIS_TLAST !== 1'b0) begin n_err++; $display("FAIL reset_tlast got=%b exp=0", m_axis.M_AXIS_TLAST); end
        n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL reset_level got=%0d exp=0", level); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic_flow();
        m_axis.M_AXIS_TREADY = 1'b1;
        validOutputs = 1'b1; result_data = 32'hA0;
        tick();
        n_cmp++; if ({m_axis.M_AXIS_TVALID, m_axis.M_AXIS_TLAST, m_axis.M_AXIS_TDATA} !== {1'b1, 1'b0, 32'hA0})
            begin n_err++; $display("FAIL basic_a0 got v=%b l=%b d=%h exp v=1 l=0 d=a0", m_axis.M_AXIS_TVALID, m_axis.M_AXIS_TLAST, m_axis.M_AXIS_TDATA); end
        n_cmp++; if (level !== 4'd1) begin n_err++; $display("FAIL basic_level_a0 got=%0d exp=1", level); end
        result_data = 32'hA1;
        tick();
        validOutputs = 1'b0;
        n_cmp++; if ({m_axis.M_AXIS_TVALID, m_axis.M_AXIS_TLAST, m_axis.M_AXIS_TDATA} !== {1'b1, 1'b1, 32'hA1})
            begin n_err++; $display("FAIL basic_a1 got v=%b l=%b d=%h exp v=1 l=1 d=a1", m_axis.M_AXIS_TVALID, m_axis.M_AXIS_TLAST, m_axis.M_AXIS_TDATA); end
        n_cmp++; if (level !== 4'd1) begin n_err++; $display("FAIL basic_level_a1 got=%0d exp=1", level); end
        tick();
        n_cmp++; if (m_axis.M_AXIS_TVALID !== 1'b0 || level !== 4'd0)
            begin n_err++; $display("FAIL basic_drained got v=%b lvl=%0d exp v=0 lvl=0", m_axis.M_AXIS_TVALID, level); end
    endtask

    task automatic test_backpressure();
        m_axis.M_AXIS_TREADY = 1'b0;
        push_words(32'h10, 8);
        tick();
        n_cmp++; if (level !== 4'd8) begin n_err++; $display("FAIL bp_level got=%0d exp=8", level); end
        n_cmp++; if (m_axis.M_AXIS_TVALID !== 1'b1 || m_axis.M_AXIS_TDATA !== 32'h10 || m_axis.M_AXIS_TLAST !== 1'b0)
            begin n_err++; $display("FAIL bp_hold got v=%b d=%h l=%b exp v=1 d=10 l=0", m_axis.M_AXIS_TVALID, m_axis.M_AXIS_TDATA, m_axis.M_AXIS_TLAST); end
        m_axis.M_AXIS_TREADY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (m_axis.M_AXIS_TVALID !== 1'b1 || m_axis.M_AXIS_TDATA !== 32'h10 + DW'(i) || m_axis.M_AXIS_TLAST !== 1'((i % 2) == 1))
                begin n_err++; $display("FAIL bp_drain[%0d] got v=%b d=%h l=%b exp v=1 d=%h l=%b", i, m_axis.M_AXIS_TVALID, m_axis.M_AXIS_TDATA, m_axis.M_AXIS_TLAST, 32'h10 + DW'(i), (i % 2) == 1); end
            tick();
        end
        n_cmp++; if (m_axis.M_AXIS_TVALID !== 1'b0 || m_axis.M_AXIS_TDATA !== 32'h0)
            begin n_err++; $display("FAIL bp_empty got v=%b d=%h exp v=0 d=0", m_axis.M_AXIS_TVALID, m_axis.M_AXIS_TDATA); end
    endtask

    task automatic test_overflow();
        m_axis.M_AXIS_TREADY = 1'b0;
        push_words(32'h20, 8);
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_pre got=%b exp=0", overflow); end
        validOutputs = 1'b1; result_data = 32'h99;
        tick();
        validOutputs = 1'b0;
        n_cmp++; if (overflow !== 1'b1 || level !== 4'd8)
            begin n_err++; $display("FAIL ovf_flag got ovf=%b lvl=%0d exp ovf=1 lvl=8", overflow, level); end
        m_axis.M_AXIS_TREADY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (m_axis.M_AXIS_TDATA !== 32'h20 + DW'(i))
                begin n_err++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, m_axis.M_AXIS_TDATA, 32'h20 + DW'(i)); end
            tick();
        end
        n_cmp++; if (m_axis.M_AXIS_TVALID !== 1'b0 || overflow !== 1'b1)
            begin n_err++; $display("FAIL ovf_sticky got v=%b ovf=%b exp v=0 ovf=1", m_axis.M_AXIS_TVALID, overflow); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++; if (overflow !== 1'b0 || level !== 4'd0 || m_axis.M_AXIS_TVALID !== 1'b0)
            begin n_err++; $display("FAIL ovf_clear got ovf=%b lvl=%0d v=%b exp 0/0/0", overflow, level, m_axis.M_AXIS_TVALID); end
    endtask

    task automatic test_full_push_pop();
        m_axis.M_AXIS_TREADY = 1'b0;
        push_words(32'h30, 8);
        m_axis.M_AXIS_TREADY = 1'b1;
        validOutputs = 1'b1; result_data = 32'h55;
        tick();
        validOutputs = 1'b0;
        n_cmp++; if (overflow !== 1'b0 || level !== 4'd8)
            begin n_err++; $display("FAIL fpp_state got ovf=%b lvl=%0d exp ovf=0 lvl=8", overflow, level); end
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] exp_d;
            exp_d = (i == 7) ? 32'h55 : 32'h31 + DW'(i);
            n_cmp++; if (m_axis.M_AXIS_TDATA !== exp_d || m_axis.M_AXIS_TLAST !== 1'((i % 2) == 0))
                begin n_err++; $display("FAIL fpp_drain[%0d] got d=%h l=%b exp d=%h l=%b", i, m_axis.M_AXIS_TDATA, m_axis.M_AXIS_TLAST, exp_d, (i % 2) == 0); end
            tick();
        end
        n_cmp++; if (m_axis.M_AXIS_TVALID !== 1'b0) begin n_err++; $display("FAIL fpp_empty got=%b exp=0", m_axis.M_AXIS_TVALID); end
    endtask

    task automatic test_clear_priority();
        // Beat counter is mid-packet (1) on entry; clear must zero it.
        m_axis.M_AXIS_TREADY = 1'b0;
        push_words(32'h40, 3);
        n_cmp++; if (level !== 4'd3) begin n_err++; $display("FAIL clr_pre_level got=%0d exp=3", level); end
        clear = 1'b1; validOutputs = 1'b1; result_data = 32'h77; m_axis.M_AXIS_TREADY = 1'b1;
        tick();
        clear = 1'b0; validOutputs = 1'b0; m_axis.M_AXIS_TREADY = 1'b0;
        n_cmp++; if (level !== 4'd0 || overflow !== 1'b0 || m_axis.M_AXIS_TVALID !== 1'b0 || m_axis.M_AXIS_TDATA !== 32'h0)
            begin n_err++; $display("FAIL clr_state got lvl=%0d ovf=%b v=%b d=%h exp 0/0/0/0", level, overflow, m_axis.M_AXIS_TVALID, m_axis.M_AXIS_TDATA); end
        push_words(32'h78, 1);
        n_cmp++; if (m_axis.M_AXIS_TDATA !== 32'h78 || m_axis.M_AXIS_TLAST !== 1'b0)
            begin n_err++; $display("FAIL clr_beat got d=%h l=%b exp d=78 l=0", m_axis.M_AXIS_TDATA, m_axis.M_AXIS_TLAST); end
        m_axis.M_AXIS_TREADY = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        // One beat (0x78) of the current packet has gone out; B0 would close it.
        m_axis.M_AXIS_TREADY = 1'b0;
        push_words(32'hB0, 1);
        n_cmp++; if (m_axis.M_AXIS_TDATA !== 32'hB0 || m_axis.M_AXIS_TLAST !== 1'b1)
            begin n_err++; $display("FAIL rst_pre got d=%h l=%b exp d=b0 l=1", m_axis.M_AXIS_TDATA, m_axis.M_AXIS_TLAST); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({m_axis.M_AXIS_TVALID, m_axis.M_AXIS_TLAST, m_axis.M_AXIS_TDATA, level, overflow} !== '0)
            begin n_err++; $display("FAIL rst_async got v=%b l=%b d=%h lvl=%0d ovf=%b exp all 0", m_axis.M_AXIS_TVALID, m_axis.M_AXIS_TLAST, m_axis.M_AXIS_TDATA, level, overflow); end
        #2 rst = 1'b1;
        push_words(32'hC0, 1);
        n_cmp++; if (m_axis.M_AXIS_TDATA !== 32'hC0 || m_axis.M_AXIS_TLAST !== 1'b0)
            begin n_err++; $display("FAIL rst_c0 got d=%h l=%b exp d=c0 l=0", m_axis.M_AXIS_TDATA, m_axis.M_AXIS_TLAST); end
        m_axis.M_AXIS_TREADY = 1'b1;
        push_words(32'hC1, 1);
        n_cmp++; if (m_axis.M_AXIS_TDATA !== 32'hC1 || m_axis.M_AXIS_TLAST !== 1'b1)
            begin n_err++; $display("FAIL rst_c1 got d=%h l=%b exp d=c1 l=1", m_axis.M_AXIS_TDATA, m_axis.M_AXIS_TLAST); end
        tick();
        n_cmp++; if (m_axis.M_AXIS_TVALID !== 1'b0) begin n_err++; $display("FAIL rst_empty got=%b exp=0", m_axis.M_AXIS_TVALID); end
    endtask

    initial begin
        m_axis.M_AXIS_TREADY = 1'b0;
        test_reset();
        test_basic_flow();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_clear_priority();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_output_stream_buffer
